// File: rtl/fft_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared definitions for the UART <-> FFT frame sequencer:
//   - state encodings (also driven out on state_o for debug)
//   - bytes-per-word derivation
//   - byte order of the UART stream (MSB first)
// Optional feature macro used by the sequencer: FFT_CTRL_RX_TIMEOUT_EN
// -----------------------------------------------------------------------------
package fft_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam bit BYTE_ORDER_MSB_FIRST = 1'b1;

    // Whole bytes in one sample/result word; width is a multiple of 8.
    function automatic int bytes_per_word(input int bit_width);
        return bit_width / 8;
    endfunction

endpackage

// File: rtl/fft_word_serializer.sv
// -----------------------------------------------------------------------------
// fft_word_serializer
// One-entry holding register for a {re,im} result pair, emitted MSB first as
// bytes over a valid/ready handshake.
//
// Parameters:
//   BIT_WIDTH  width of one of re/im; the held word is 2*BIT_WIDTH bits
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load_valid   capture load_data when the register is empty
//   load_data    {re,im} pair to serialise
//   empty        holding register is free (can accept load_data)
//   tx_valid     byte offered downstream
//   tx_byte      current byte, stable while tx_valid && !tx_ready
//   tx_ready     downstream accepts tx_byte this cycle
//   word_done    last byte of the word transfers this cycle
// -----------------------------------------------------------------------------
module fft_word_serializer #(
    parameter int BIT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    input  logic [2*BIT_WIDTH-1:0] load_data,
    output logic                   empty,
    output logic                   tx_valid,
    output logic [7:0]             tx_byte,
    input  logic                   tx_ready,
    output logic                   word_done
);

    localparam int WIDTH = 2 * BIT_WIDTH;
    localparam int NB    = WIDTH / 8;
    localparam int CW    = $clog2(NB);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

    logic [WIDTH-1:0] hold;
    logic             full;
    logic [CW-1:0]    byte_cnt;
    logic             xfer;

    // The word is shifted left as bytes leave, so the outgoing byte is always
    // the top byte; after the last shift the register reads back as zero.
    assign empty     = !full;
    assign tx_valid  = full;
    assign tx_byte   = hold[WIDTH-1 -: 8];
    assign xfer      = full && tx_ready;
    assign word_done = xfer && (byte_cnt == LAST_BYTE);

    // NOTE: the holding register is reset along with its control bits so that
    // tx_byte reads 0 straight out of reset instead of stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= '0;
            full     <= 1'b0;
            byte_cnt <= '0;
        end else if (load_valid && !full) begin
            hold     <= load_data;
            full     <= 1'b1;
            byte_cnt <= '0;
        end else if (xfer) begin
            hold <= hold << 8;
            if (byte_cnt == LAST_BYTE) begin
                full     <= 1'b0;
                byte_cnt <= '0;
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// fft_frame_ctrl
// Frame sequencer between a UART byte receiver/transmitter and a streaming FFT.
// Packs BPW received bytes (MSB first) into each signed sample, loads N samples,
// pulses fft_start, waits for fft_done, then streams N {re,im} result pairs back
// out as 2*BPW bytes each under tx backpressure.
//
// Optional feature macro: FFT_CTRL_RX_TIMEOUT_EN
//   defined   -> parameter RX_TIMEOUT and sticky output rx_timeout; an idle gap
//                of RX_TIMEOUT cycles in LOAD discards the partial frame.
//   undefined -> LOAD waits indefinitely for bytes.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rx_valid, rx_byte           received byte strobe and data
//   fft_in_valid/data/last      sample stream to the FFT (last on sample N-1)
//   fft_start                   one-cycle start pulse, the cycle after fft_in_last
//   fft_done                    one-cycle completion pulse, honoured only in RUN
//   fft_out_valid/re/im/ready   result pair handshake (ready only in DRAIN)
//   tx_valid, tx_byte, tx_ready byte stream to the UART transmitter
//   rx_drop                     sticky: byte arrived while not loading
//   rx_timeout                  sticky: LOAD timed out (feature build only)
//   state_o                     current state encoding
// -----------------------------------------------------------------------------
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = 24,
    parameter int N         = 16
`ifdef FFT_CTRL_RX_TIMEOUT_EN
   ,parameter int RX_TIMEOUT = 50000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_byte,
    output logic                 fft_in_valid,
    output logic [BIT_WIDTH-1:0] fft_in_data,
    output logic                 fft_in_last,
    output logic                 fft_start,
    input  logic                 fft_done,
    input  logic                 fft_out_valid,
    input  logic [BIT_WIDTH-1:0] fft_out_re,
    input  logic [BIT_WIDTH-1:0] fft_out_im,
    output logic                 fft_out_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_byte,
    input  logic                 tx_ready,
    output logic                 rx_drop,
`ifdef FFT_CTRL_RX_TIMEOUT_EN
    output logic                 rx_timeout,
`endif
    output logic [2:0]           state_o
);

    localparam int BPW    = bytes_per_word(BIT_WIDTH);
    localparam int SAMP_W = $clog2(N);
    localparam int BYTE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [SAMP_W-1:0] LAST_SAMPLE = SAMP_W'(N - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE   = BYTE_W'(BPW - 1);

`ifdef FFT_CTRL_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(RX_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(RX_TIMEOUT - 1);
    logic [TO_W-1:0] idle_cnt;
`endif

    logic [2:0]           state;
    logic [BYTE_W-1:0]    byte_cnt;
    logic [SAMP_W-1:0]    samp_cnt;
    logic [SAMP_W-1:0]    pair_cnt;
    logic [BIT_WIDTH-1:0] asm_word;
    logic [BIT_WIDTH-1:0] asm_next;
    logic                 accept_byte;
    logic                 pair_load;
    logic                 pair_sent;
    logic                 ser_empty;

    // IDLE treats the first byte exactly like a LOAD byte (byte 0 of sample 0).
    assign accept_byte   = rx_valid && ((state == ST_IDLE) || (state == ST_LOAD));
    assign fft_out_ready = (state == ST_DRAIN) && ser_empty;
    assign pair_load     = fft_out_valid && fft_out_ready;
    assign state_o       = state;

    // Shifting each byte in from the bottom leaves byte 0 in the top byte lane
    // once the word is complete, so no byte index is needed.
    // NOTE: both branches assign asm_next, so this block cannot infer a latch.
    always_comb begin
        if (BYTE_ORDER_MSB_FIRST) asm_next = BIT_WIDTH'({asm_word, rx_byte});
        else                      asm_next = BIT_WIDTH'({rx_byte, asm_word} >> 8);
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // branch below sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            byte_cnt     <= '0;
            samp_cnt     <= '0;
            pair_cnt     <= '0;
            asm_word     <= '0;
            fft_in_valid <= 1'b0;
            fft_in_last  <= 1'b0;
            fft_in_data  <= '0;
            fft_start    <= 1'b0;
            rx_drop      <= 1'b0;
`ifdef FFT_CTRL_RX_TIMEOUT_EN
            idle_cnt     <= '0;
            rx_timeout   <= 1'b0;
`endif
        end else begin
            fft_in_valid <= 1'b0;
            fft_in_last  <= 1'b0;
            fft_start    <= 1'b0;

            if (rx_valid && !accept_byte) rx_drop <= 1'b1;

            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (accept_byte) begin
                        state    <= ST_LOAD;
                        asm_word <= asm_next;
`ifdef FFT_CTRL_RX_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt     <= '0;
                            fft_in_valid <= 1'b1;
                            fft_in_data  <= asm_next;
                            fft_in_last  <= (samp_cnt == LAST_SAMPLE);
                            if (samp_cnt == LAST_SAMPLE) begin
                                samp_cnt <= '0;
                                state    <= ST_START;
                            end else begin
                                samp_cnt <= samp_cnt + 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
`ifdef FFT_CTRL_RX_TIMEOUT_EN
                    else if (state == ST_LOAD) begin
                        // Abandon the partial frame; no fft_start follows.
                        if (idle_cnt == TIMEOUT_LAST) begin
                            state      <= ST_IDLE;
                            byte_cnt   <= '0;
                            samp_cnt   <= '0;
                            idle_cnt   <= '0;
                            rx_timeout <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
`endif
                end
                ST_START: begin
                    fft_start <= 1'b1;
                    state     <= ST_RUN;
                end
                ST_RUN: begin
                    if (fft_done) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pair_sent) begin
                        if (pair_cnt == LAST_SAMPLE) begin
                            pair_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            pair_cnt <= pair_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fft_word_serializer #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .load_valid (pair_load),
        .load_data  ({fft_out_re, fft_out_im}),
        .empty      (ser_empty),
        .tx_valid   (tx_valid),
        .tx_byte    (tx_byte),
        .tx_ready   (tx_ready),
        .word_done  (pair_sent)
    );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_ctrl
// Directed bench for fft_frame_ctrl (BIT_WIDTH=24, N=16): reset values, frame
// loading and packing, start timing, result draining with and without tx
// backpressure, dropped bytes, reset during DRAIN and, when
// FFT_CTRL_RX_TIMEOUT_EN is defined, the LOAD timeout.
// -----------------------------------------------------------------------------
module tb_fft_frame_ctrl;

    localparam int W   = 24;
    localparam int N   = 16;
    localparam int BPW = W / 8;
    localparam int NBYTES = 2 * BPW * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         fft_in_valid;
    logic [W-1:0] fft_in_data;
    logic         fft_in_last;
    logic         fft_start;
    logic         fft_done;
    logic         fft_out_valid;
    logic [W-1:0] fft_out_re;
    logic [W-1:0] fft_out_im;
    logic         fft_out_ready;
    logic         tx_valid;
    logic [7:0]   tx_byte;
    logic         tx_ready;
    logic         rx_drop;
`ifdef FFT_CTRL_RX_TIMEOUT_EN
    logic         rx_timeout;
`endif
    logic [2:0]   state_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_frame_ctrl #(
        .BIT_WIDTH (W),
        .N         (N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .fft_in_valid  (fft_in_valid),
        .fft_in_data   (fft_in_data),
        .fft_in_last   (fft_in_last),
        .fft_start     (fft_start),
        .fft_done      (fft_done),
        .fft_out_valid (fft_out_valid),
        .fft_out_re    (fft_out_re),
        .fft_out_im    (fft_out_im),
        .fft_out_ready (fft_out_ready),
        .tx_valid      (tx_valid),
        .tx_byte       (tx_byte),
        .tx_ready      (tx_ready),
        .rx_drop       (rx_drop),
`ifdef FFT_CTRL_RX_TIMEOUT_EN
        .rx_timeout    (rx_timeout),
`endif
        .state_o       (state_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Result pair the stand-in FFT returns for index p.
    function automatic logic [2*W-1:0] pair_word(input int p, input bit indexed);
        if (!indexed) return {24'h123456, 24'hABCDEF};
        return {W'(24'h654300 + p), W'(24'h0FED00 + p)};
    endfunction

    // Sends one frame (sample i = i, optionally sample 0 = -2) and checks the
    // sample stream, the last flag and the start pulse.
    task automatic load_frame(input bit neg_first, input bit gaps, input string tag);
        int n_valid   = 0;
        int bad_data  = 0;
        int bad_last  = 0;
        int n_start   = 0;
        int last_cyc  = -100;
        int start_cyc = -200;
        logic [W-1:0] first_data = '0;
        logic [W-1:0] expd;
        logic [W-1:0] wv;
        fork
            begin
                for (int s = 0; s < N; s++) begin
                    wv = (neg_first && s == 0) ? 24'hFFFFFE : W'(s);
                    for (int b = 0; b < BPW; b++) begin
                        rx_valid = 1'b1;
                        rx_byte  = 8'(wv >> (8 * (BPW - 1 - b)));
                        tick();
                        if (gaps) begin
                            rx_valid = 1'b0;
                            tick();
                        end
                    end
                end
                rx_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 220; c++) begin
                    tick();
                    if (fft_in_valid) begin
                        expd = (neg_first && n_valid == 0) ? 24'hFFFFFE : W'(n_valid);
                        if (n_valid == 0) first_data = fft_in_data;
                        if (fft_in_data !== expd) bad_data++;
                        if (fft_in_last !== (n_valid == N - 1)) bad_last++;
                        if (fft_in_last) last_cyc = c;
                        n_valid++;
                    end else if (fft_in_last) begin
                        bad_last++;
                    end
                    if (fft_start) begin
                        n_start++;
                        start_cyc = c;
                    end
                end
            end
        join
        check({tag, "_n_samples"}, 64'(n_valid), 64'(N));
        check({tag, "_data"}, 64'(bad_data), 64'd0);
        check({tag, "_last"}, 64'(bad_last), 64'd0);
        check({tag, "_n_start"}, 64'(n_start), 64'd1);
        check({tag, "_start_after_last"}, 64'(start_cyc - last_cyc), 64'd1);
        if (neg_first) check({tag, "_sign_pack"}, 64'(first_data), 64'hFFFFFE);
        check({tag, "_state_run"}, 64'(state_o), 64'd3);
    endtask

    // Feeds N pairs and collects all bytes; checks order, stability under
    // stall, holding-register readiness and (without backpressure) throughput.
    task automatic drain(input bit bp, input bit indexed, input string tag);
        int n_bytes   = 0;
        int bad_order = 0;
        int bad_stall = 0;
        int bad_ready = 0;
        int bad_gap   = 0;
        int last_xfer = -10;
        bit stalled   = 1'b0;
        logic [7:0]     stalled_byte = '0;
        logic [7:0]     eb;
        logic [2*W-1:0] pw;
        fork
            begin
                for (int p = 0; p < N; p++) begin
                    fft_out_valid = 1'b1;
                    {fft_out_re, fft_out_im} = pair_word(p, indexed);
                    for (int g = 0; g < 400 && !fft_out_ready; g++) tick();
                    tick();
                end
                fft_out_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 3000 && n_bytes < NBYTES; c++) begin
                    tx_ready = bp ? (c % 3 == 0) : 1'b1;
                    if (stalled && (!tx_valid || tx_byte !== stalled_byte)) bad_stall++;
                    if (tx_valid && fft_out_ready) bad_ready++;
                    if (tx_valid && tx_ready) begin
                        pw = pair_word(n_bytes / (2 * BPW), indexed);
                        eb = 8'(pw >> (8 * (2 * BPW - 1 - (n_bytes % (2 * BPW)))));
                        if (tx_byte !== eb) bad_order++;
                        if ((n_bytes % (2 * BPW)) != 0 && last_xfer != c - 1) bad_gap++;
                        last_xfer = c;
                        n_bytes++;
                        stalled = 1'b0;
                    end else if (tx_valid) begin
                        stalled      = 1'b1;
                        stalled_byte = tx_byte;
                    end
                    tick();
                end
                tx_ready = 1'b0;
            end
        join
        check({tag, "_n_bytes"}, 64'(n_bytes), 64'(NBYTES));
        check({tag, "_byte_order"}, 64'(bad_order), 64'd0);
        check({tag, "_ready_while_full"}, 64'(bad_ready), 64'd0);
        if (bp) check({tag, "_stall_stable"}, 64'(bad_stall), 64'd0);
        else    check({tag, "_consecutive"}, 64'(bad_gap), 64'd0);
        check({tag, "_state_idle"}, 64'(state_o), 64'd0);
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
    endtask

    initial begin
        int seen_tx;
        rst           = 1'b1;
        rx_valid      = 1'b0;
        rx_byte       = '0;
        fft_done      = 1'b0;
        fft_out_valid = 1'b0;
        fft_out_re    = '0;
        fft_out_im    = '0;
        tx_ready      = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_fft_in_valid",  64'(fft_in_valid),  64'd0);
        check("rst_fft_in_last",   64'(fft_in_last),   64'd0);
        check("rst_fft_start",     64'(fft_start),     64'd0);
        check("rst_fft_out_ready", 64'(fft_out_ready), 64'd0);
        check("rst_tx_valid",      64'(tx_valid),      64'd0);
        check("rst_tx_byte",       64'(tx_byte),       64'd0);
        check("rst_fft_in_data",   64'(fft_in_data),   64'd0);
        check("rst_rx_drop",       64'(rx_drop),       64'd0);
        check("rst_state",         64'(state_o),       64'd0);
`ifdef FFT_CTRL_RX_TIMEOUT_EN
        check("rst_rx_timeout",    64'(rx_timeout),    64'd0);
`endif
        rst = 1'b0;
        tick();

        // fft_done and fft_out_valid outside RUN/DRAIN are ignored
        fft_done      = 1'b1;
        fft_out_valid = 1'b1;
        check("idle_out_ready", 64'(fft_out_ready), 64'd0);
        tick();
        fft_done      = 1'b0;
        fft_out_valid = 1'b0;
        check("idle_done_ignored", 64'(state_o), 64'd0);

        // Frame 1: back-to-back bytes, byte dropped in RUN, full-rate drain
        load_frame(1'b0, 1'b0, "f1");
        rx_valid = 1'b1;
        rx_byte  = 8'h55;
        tick();
        rx_valid = 1'b0;
        check("run_rx_drop", 64'(rx_drop), 64'd1);
        check("run_state_kept", 64'(state_o), 64'd3);
        pulse_done();
        check("done_to_drain", 64'(state_o), 64'd4);
        drain(1'b0, 1'b0, "d1");
        check("rx_drop_sticky", 64'(rx_drop), 64'd1);

        // Frame 2: gapped bytes with a negative sample, 1-of-3 tx_ready
        load_frame(1'b1, 1'b1, "f2");
        pulse_done();
        drain(1'b1, 1'b1, "d2");

        // Frame 3: reset while a pair is being serialised
        load_frame(1'b0, 1'b0, "f3");
        pulse_done();
        fft_out_valid = 1'b1;
        {fft_out_re, fft_out_im} = pair_word(0, 1'b0);
        tx_ready = 1'b0;
        for (int g = 0; g < 20 && !tx_valid; g++) tick();
        check("f3_tx_before_rst", 64'(tx_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        check("mid_rst_state",    64'(state_o),  64'd0);
        check("mid_rst_rx_drop",  64'(rx_drop),  64'd0);
        tx_ready = 1'b1;
        seen_tx = 0;
        for (int g = 0; g < 10; g++) begin
            if (tx_valid || fft_out_ready) seen_tx++;
            tick();
        end
        check("mid_rst_no_output", 64'(seen_tx), 64'd0);
        fft_out_valid = 1'b0;
        tx_ready      = 1'b0;

`ifdef FFT_CTRL_RX_TIMEOUT_EN
        begin
            int n_start = 0;
            for (int b = 0; b < 5; b++) begin
                rx_valid = 1'b1;
                rx_byte  = 8'(b);
                tick();
            end
            rx_valid = 1'b0;
            check("to_state_load", 64'(state_o), 64'd1);
            for (int c = 0; c < 50000; c++) begin
                tick();
                if (fft_start) n_start++;
            end
            check("to_rx_timeout", 64'(rx_timeout), 64'd1);
            check("to_state_idle", 64'(state_o), 64'd0);
            check("to_no_start", 64'(n_start), 64'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
